countdown_ctrl: RTL and testbench
=================================

// Module: countdown_ctrl
//
// PURPOSE
// Run/pause/alarm controller for the countdown timer. Divides CLK down to a
// count tick and drives the CE input of the LSB down-counter of the cascade.
// Consumes the cascade's all-digits-zero flag to detect expiry, then raises a
// timed, blinking alarm. Issues a LOAD pulse that returns the counter chain to
// its preset. Sits directly upstream of the down-counter chain; START and STOP
// arrive from the debounced button logic.
//
// PARAMETERS
// TICK_DIV     100_000_000  CLK cycles per count tick (1 Hz at 100 MHz); >= 2
// ALARM_TICKS  5            number of count ticks the alarm stays active; >= 1
// BLINK_DIV    50_000_000   CLK cycles per BLINK half-period; >= 1
//
// PORTS
// CLK       in   1  system clock; all logic on posedge
// CLR       in   1  synchronous reset, active-high
// START     in   1  one-cycle pulse: start or resume counting
// STOP      in   1  one-cycle pulse: pause, or abort and reload
// CNT_ZERO  in   1  high while every digit of the counter chain is zero
// CE        out  1  one-cycle count enable to the LSB counter
// LOAD      out  1  one-cycle pulse: reload counter chain to its preset
// RUNNING   out  1  high in RUN
// ALARM     out  1  high in ALARM
// BLINK     out  1  alarm blink output; 0 outside ALARM
// STATE     out  2  IDLE=00, RUN=01, PAUSE=10, ALARM=11
//
// BEHAVIOUR
// - Reset (CLR=1 at posedge): STATE=IDLE, pre_cnt=0, alarm counter=0; next cycle all outputs 0.
// - pre_cnt: 0..TICK_DIV-1, width $clog2(TICK_DIV). Increments in RUN and ALARM, wraps to 0.
//   Holds in PAUSE. Cleared on IDLE->RUN and on every entry to ALARM.
// - tick = (pre_cnt == TICK_DIV-1).
// - CE: combinational. CE = (STATE==RUN) & tick & ~CNT_ZERO & ~STOP.
//   No CE is ever issued while CNT_ZERO=1 or outside RUN.
// - IDLE: STOP -> stay IDLE, LOAD=1 next cycle.
//   Otherwise START & ~CNT_ZERO -> RUN. START while CNT_ZERO=1 is ignored.
// - RUN, priority order:
//   1. CNT_ZERO=1 -> ALARM (expiry beats STOP).
//   2. STOP -> PAUSE.
//   3. START is ignored.
// - PAUSE:
//   STOP -> IDLE, LOAD=1 next cycle.
//   START -> RUN with pre_cnt retained, so the partial tick is resumed, not restarted.
// - ALARM:
//   - ALARM=1; BLINK=1 on entry and toggles every BLINK_DIV cycles.
//   - Alarm counter increments on each tick. When it reaches ALARM_TICKS -> IDLE, LOAD=1 next cycle.
//   - START or STOP -> IDLE immediately, LOAD=1 next cycle.
// - START and STOP in the same cycle: STOP wins in every state.
// - LOAD is registered: high exactly one cycle, in the first IDLE cycle after the causing edge.
// - Latency:
//   - STATE changes one cycle after the sampled input.
//   - CE is asserted in the same cycle that tick is true; the counter updates at the following edge.
// - CLR mid-operation: abort any state to IDLE with no LOAD pulse (counters have their own reset).
//
// TESTING  (TICK_DIV=4, ALARM_TICKS=2, BLINK_DIV=2)
// 1. CLR, then START with CNT_ZERO=0 -> STATE=01 next cycle; CE high on the 4th RUN cycle,
//    then every 4 cycles thereafter.
// 2. STOP in RUN at pre_cnt=2 -> PAUSE, CE stays 0. START -> RUN; pre_cnt resumes 2,3;
//    CE on the 2nd RUN cycle.
// 3. CNT_ZERO=1 in RUN -> CE=0 that cycle; ALARM next cycle.
//    ALARM=1 for 8 cycles; BLINK pattern 1,1,0,0,1,1,0,0.
//    Then STATE=IDLE with LOAD=1 for exactly 1 cycle.
// 4. START and STOP together in RUN -> PAUSE. Same pair in PAUSE -> IDLE with LOAD pulse.
// 5. START in IDLE with CNT_ZERO=1 -> STATE stays 00; CE, LOAD stay 0.
//    CLR during ALARM -> next cycle: STATE=00, ALARM=BLINK=LOAD=0.

Source files
------------

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: run/pause/alarm sequencer for the countdown timer.
// Divides CLK to a count tick, gates CE, times the blinking alarm.
module countdown_ctrl #(
   parameter int TICK_DIV    = 100_000_000,
   parameter int ALARM_TICKS = 5,
   parameter int BLINK_DIV   = 50_000_000
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic       START,
   input  logic       STOP,
   input  logic       CNT_ZERO,
   output logic       CE,
   output logic       LOAD,
   output logic       RUNNING,
   output logic       ALARM,
   output logic       BLINK,
   output logic [1:0] STATE
);

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_ALARM = 2'b11;

   localparam int PW = $clog2(TICK_DIV);
   localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
   localparam logic [AW-1:0] ALST = AW'(ALARM_TICKS - 1);
   localparam logic [BW-1:0] BLST = BW'(BLINK_DIV - 1);

   logic [1:0]    state;
   logic [PW-1:0] pre_cnt;
   logic [AW-1:0] alm_cnt;
   logic [BW-1:0] blk_cnt;
   logic          blink;
   logic          load;
   logic          tick;

   assign tick    = (pre_cnt == PMAX);
   assign CE      = (state == S_RUN) & tick & ~CNT_ZERO & ~STOP;
   assign LOAD    = load;
   assign RUNNING = (state == S_RUN);
   assign ALARM   = (state == S_ALARM);
   assign BLINK   = blink & (state == S_ALARM);
   assign STATE   = state;

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state   <= S_IDLE;
         pre_cnt <= '0;
         alm_cnt <= '0;
         blk_cnt <= '0;
         blink   <= 1'b0;
         load    <= 1'b0;
      end else begin
         load <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (STOP) begin
                  load <= 1'b1;
               end else if (START && !CNT_ZERO) begin
                  state   <= S_RUN;
                  pre_cnt <= '0;
               end
            end
            S_RUN: begin
               if (CNT_ZERO) begin
                  state   <= S_ALARM;
                  pre_cnt <= '0;
                  alm_cnt <= '0;
                  blk_cnt <= '0;
                  blink   <= 1'b1;
               end else if (STOP) begin
                  // freeze the prescaler so a pause resumes the partial tick
                  state <= S_PAUSE;
               end else begin
                  pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
               end
            end
            S_PAUSE: begin
               if (STOP) begin
                  state <= S_IDLE;
                  load  <= 1'b1;
               end else if (START) begin
                  state <= S_RUN;
               end
            end
            S_ALARM: begin
               if (blk_cnt == BLST) begin
                  blk_cnt <= '0;
                  blink   <= ~blink;
               end else begin
                  blk_cnt <= blk_cnt + 1'b1;
               end
               if (START || STOP || (tick && alm_cnt == ALST)) begin
                  state <= S_IDLE;
                  load  <= 1'b1;
               end else begin
                  pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
                  if (tick)
                     alm_cnt <= alm_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: scoreboard bench for countdown_ctrl.
// Per-cycle expected outputs are queued at drive time, compared at negedge.
module tb_countdown_ctrl;

   localparam logic [1:0] I = 2'd0;
   localparam logic [1:0] R = 2'd1;
   localparam logic [1:0] P = 2'd2;
   localparam logic [1:0] A = 2'd3;

   logic       CLK = 1'b0;
   logic       CLR = 1'b1;
   logic       START = 1'b0;
   logic       STOP = 1'b0;
   logic       CNT_ZERO = 1'b0;
   logic       CE, LOAD, RUNNING, ALARM, BLINK;
   logic [1:0] STATE;

   logic [6:0] q[$];
   int         checks = 0;
   int         failures = 0;
   string      phase = "init";

   countdown_ctrl #(
      .TICK_DIV(4),
      .ALARM_TICKS(2),
      .BLINK_DIV(2)
   ) dut (
      .CLK(CLK),
      .CLR(CLR),
      .START(START),
      .STOP(STOP),
      .CNT_ZERO(CNT_ZERO),
      .CE(CE),
      .LOAD(LOAD),
      .RUNNING(RUNNING),
      .ALARM(ALARM),
      .BLINK(BLINK),
      .STATE(STATE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [6:0] E(input logic [1:0] s,
                                    input logic ce,
                                    input logic ld,
                                    input logic bl);
      return {s, s == R, s == A, bl, ce, ld};
   endfunction

   task automatic cyc(input logic st, input logic sp,
                      input logic z, input logic c,
                      input logic [6:0] e, input bit en);
      @(posedge CLK);
      #1;
      START    = st;
      STOP     = sp;
      CNT_ZERO = z;
      CLR      = c;
      if (en)
         q.push_back(e);
   endtask

   always @(negedge CLK) begin
      logic [6:0] e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk(phase, {STATE, RUNNING, ALARM, BLINK, CE, LOAD}, e);
      end
   end

   initial begin
      phase = "reset";
      cyc(0, 0, 0, 1, E(I, 0, 0, 0), 0);
      cyc(0, 0, 0, 0, E(I, 0, 0, 0), 1);

      phase = "run";
      cyc(1, 0, 0, 0, E(I, 0, 0, 0), 1);
      for (int i = 0; i < 8; i++)
         cyc(0, 0, 0, 0, E(R, (i % 4) == 3, 0, 0), 1);
      cyc(0, 0, 0, 0, E(R, 0, 0, 0), 1);
      cyc(0, 0, 0, 0, E(R, 0, 0, 0), 1);

      phase = "pause";
      cyc(0, 1, 0, 0, E(R, 0, 0, 0), 1);
      for (int i = 0; i < 3; i++)
         cyc(0, 0, 0, 0, E(P, 0, 0, 0), 1);
      cyc(1, 0, 0, 0, E(P, 0, 0, 0), 1);
      phase = "resume";
      cyc(0, 0, 0, 0, E(R, 0, 0, 0), 1);
      cyc(0, 0, 0, 0, E(R, 1, 0, 0), 1);
      cyc(0, 0, 0, 0, E(R, 0, 0, 0), 1);
      cyc(0, 0, 0, 0, E(R, 0, 0, 0), 1);
      cyc(0, 0, 0, 0, E(R, 0, 0, 0), 1);

      phase = "expire";
      cyc(0, 0, 1, 0, E(R, 0, 0, 0), 1);
      for (int i = 0; i < 8; i++)
         cyc(0, 0, 1, 0, E(A, 0, 0, (i % 4) < 2), 1);
      cyc(0, 0, 1, 0, E(I, 0, 1, 0), 1);

      phase = "zero_start";
      cyc(1, 0, 1, 0, E(I, 0, 0, 0), 1);
      cyc(0, 0, 1, 0, E(I, 0, 0, 0), 1);

      phase = "both";
      cyc(1, 0, 0, 0, E(I, 0, 0, 0), 1);
      cyc(1, 1, 0, 0, E(R, 0, 0, 0), 1);
      cyc(1, 1, 0, 0, E(P, 0, 0, 0), 1);
      cyc(0, 0, 0, 0, E(I, 0, 1, 0), 1);
      cyc(0, 0, 0, 0, E(I, 0, 0, 0), 1);

      phase = "idle_stop";
      cyc(0, 1, 0, 0, E(I, 0, 0, 0), 1);
      cyc(0, 0, 0, 0, E(I, 0, 1, 0), 1);
      cyc(0, 0, 0, 0, E(I, 0, 0, 0), 1);

      phase = "zero_beats_stop";
      cyc(1, 0, 0, 0, E(I, 0, 0, 0), 1);
      cyc(0, 1, 1, 0, E(R, 0, 0, 0), 1);
      cyc(0, 0, 1, 0, E(A, 0, 0, 1), 1);
      cyc(0, 1, 1, 0, E(A, 0, 0, 1), 1);
      cyc(0, 0, 0, 0, E(I, 0, 1, 0), 1);
      cyc(0, 0, 0, 0, E(I, 0, 0, 0), 1);

      phase = "start_abort";
      cyc(1, 0, 0, 0, E(I, 0, 0, 0), 1);
      cyc(0, 0, 1, 0, E(R, 0, 0, 0), 1);
      cyc(1, 0, 0, 0, E(A, 0, 0, 1), 1);
      cyc(0, 0, 0, 0, E(I, 0, 1, 0), 1);
      cyc(0, 0, 0, 0, E(I, 0, 0, 0), 1);

      phase = "clr_alarm";
      cyc(1, 0, 0, 0, E(I, 0, 0, 0), 1);
      cyc(0, 0, 1, 0, E(R, 0, 0, 0), 1);
      cyc(0, 0, 0, 0, E(A, 0, 0, 1), 1);
      cyc(0, 0, 0, 1, E(A, 0, 0, 1), 1);
      cyc(0, 0, 0, 0, E(I, 0, 0, 0), 1);
      cyc(0, 0, 0, 0, E(I, 0, 0, 0), 1);

      @(negedge CLK);
      #1;
      phase = "drain";
      chk(phase, q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
